// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: one full-duplex transfer of 8/16/24/32 bits, LSB first,
// with programmable SCLK half-period and chip-select setup/hold times.
module spi_master_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            SPI_DATA_LEN,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  SCLK,
    output logic                  CS_n,
    output logic                  MOSI,
    input  logic                  MISO
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [15:0]           cnt;
    logic [5:0]            bit_cnt;
    logic [5:0]            nbits;
    logic [5:0]            len_bits;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic [DATA_WIDTH-1:0] rx_q;
    logic                  sclk_q;
    logic                  mosi_q;
    logic                  phase_end;
    logic                  last_fall;

    assign len_bits  = {1'b0, SPI_DATA_LEN, 3'b000} + 6'd8;
    assign phase_end = (cnt == 16'(CLK_DIV - 1));
    // Falling SCLK edge that closes the final bit period.
    assign last_fall = (state == S_SHIFT) && phase_end && sclk_q &&
                       (bit_cnt == nbits - 6'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            nbits   <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // tx_sh holds the bits still to be sent; bit 0 goes out now.
                        tx_sh   <= tx_data >> 1;
                        mosi_q  <= tx_data[0];
                        nbits   <= len_bits;
                        rx_sh   <= '0;
                        bit_cnt <= '0;
                        cnt     <= '0;
                    end
                end
                S_SETUP, S_HOLD: begin
                    cnt <= (state_nxt != state) ? '0 : cnt + 16'd1;
                end
                S_SHIFT: begin
                    if (phase_end) begin
                        cnt    <= '0;
                        sclk_q <= ~sclk_q;
                        if (!sclk_q) begin
                            // Rising edge: new bit enters at N-1 and the word moves right.
                            rx_sh <= (rx_sh >> 1) |
                                     (DATA_WIDTH'(MISO) << (nbits - 6'd1));
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                            if (last_fall) begin
                                mosi_q <= 1'b0;
                            end else begin
                                mosi_q <= tx_sh[0];
                                tx_sh  <= tx_sh >> 1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: ;
            endcase
            if (state == S_HOLD && state_nxt == S_DONE) begin
                rx_q <= rx_sh;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SETUP;
            S_SETUP: if (cnt == 16'(CS_SETUP - 1)) state_nxt = S_SHIFT;
            S_SHIFT: if (last_fall) state_nxt = S_HOLD;
            S_HOLD:  if (cnt == 16'(CS_HOLD - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        CS_n    = (state == S_IDLE) || (state == S_DONE);
        SCLK    = sclk_q;
        MOSI    = mosi_q;
        rx_data = rx_q;
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: vector table of transfers plus hand-written
// sequences for start-while-busy, mid-transfer reset and back-to-back starts.
module tb_spi_master_ctrl;

    localparam int DW       = 32;
    localparam int CLK_DIV  = 2;
    localparam int CS_SETUP = 1;
    localparam int CS_HOLD  = 1;
    localparam int NVEC     = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    SPI_DATA_LEN;
    logic [DW-1:0] tx_data;
    logic          busy;
    logic          done;
    logic [DW-1:0] rx_data;
    logic          SCLK;
    logic          CS_n;
    logic          MOSI;
    logic          MISO;

    // slave model state
    logic [31:0]   miso_pat;
    logic          loopback;
    logic          miso_bit;
    int            rise_cnt;
    logic [31:0]   mosi_cap;
    int            done_cnt;
    int            busy_falls;
    logic          busy_prev;
    logic          sclk_prev;

    // scoreboard
    logic [DW-1:0] exp_rx_q[$];
    logic [DW-1:0] exp_mosi_q[$];
    int            exp_n_q[$];
    int            exp_lat_q[$];

    int checks;
    int failures;
    int exp_dones;

    typedef struct {
        logic [1:0]  len;
        logic [31:0] tx;
        logic [31:0] miso;
        logic        loop;
        int          n;
        logic [31:0] exp_rx;
        logic [31:0] exp_mosi;
        int          exp_lat;
    } vec_t;

    vec_t vecs[NVEC];

    spi_master_ctrl #(
        .DATA_WIDTH(DW),
        .CLK_DIV   (CLK_DIV),
        .CS_SETUP  (CS_SETUP),
        .CS_HOLD   (CS_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .SPI_DATA_LEN(SPI_DATA_LEN),
        .tx_data     (tx_data),
        .busy        (busy),
        .done        (done),
        .rx_data     (rx_data),
        .SCLK        (SCLK),
        .CS_n        (CS_n),
        .MOSI        (MOSI),
        .MISO        (MISO)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- slave model / monitor ----------------
    assign miso_bit = (rise_cnt < 32) ? miso_pat[rise_cnt[4:0]] : 1'b0;
    assign MISO     = loopback ? MOSI : miso_bit;

    initial begin
        rise_cnt   = 0;
        mosi_cap   = '0;
        done_cnt   = 0;
        busy_falls = 0;
        busy_prev  = 1'b0;
        sclk_prev  = 1'b0;
    end

    always @(negedge clk) begin
        if (busy && !busy_prev) begin
            rise_cnt = 0;
            mosi_cap = '0;
        end else if (SCLK && !sclk_prev) begin
            if (rise_cnt < 32) mosi_cap[rise_cnt[4:0]] = MOSI;
            rise_cnt++;
        end
        if (done) done_cnt++;
        if (!busy && busy_prev) busy_falls++;
        busy_prev = busy;
        sclk_prev = SCLK;
    end

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input vec_t v);
        exp_rx_q.push_back(v.exp_rx);
        exp_mosi_q.push_back(v.exp_mosi);
        exp_n_q.push_back(v.n);
        exp_lat_q.push_back(v.exp_lat);
        miso_pat = v.miso;
        loopback = v.loop;
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge,
    // having scrambled the request inputs so late changes can be seen to be ignored.
    task automatic pulse_start(input logic [1:0] len, input logic [31:0] tx);
        start        = 1'b1;
        SPI_DATA_LEN = len;
        tx_data      = tx;
        @(negedge clk);
        start        = 1'b0;
        SPI_DATA_LEN = 2'b11;
        tx_data      = $urandom;
    endtask

    // k0 = negedges already elapsed since the accept edge. Latency is the edge
    // index (from the accept edge) at which done is captured high.
    task automatic wait_done(input int k0, input int budget);
        int k;
        bit seen;
        logic [31:0] er;
        logic [31:0] em;
        int en;
        int el;
        k    = k0;
        seen = 1'b0;
        while (!seen && k < k0 + budget) begin
            @(negedge clk);
            k++;
            if (done) seen = 1'b1;
        end
        if (exp_rx_q.size() == 0) begin
            check("scoreboard_empty", 64'd0, 64'd1);
            return;
        end
        er = exp_rx_q.pop_front();
        em = exp_mosi_q.pop_front();
        en = exp_n_q.pop_front();
        el = exp_lat_q.pop_front();
        if (!seen) begin
            check("done_timeout", 64'(k), 64'(el));
            return;
        end
        check("rx_data", 64'(rx_data), 64'(er));
        check("mosi_bits", 64'(mosi_cap), 64'(em));
        check("sclk_rises", 64'(rise_cnt), 64'(en));
        check("done_latency", 64'(k + 1), 64'(el));
        @(negedge clk);
        check("done_width", 64'(done), 64'd0);
    endtask

    task automatic wait_rises(input int n, input int budget, output int waited);
        waited = 0;
        while (rise_cnt < n && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (rise_cnt < n) check("rise_timeout", 64'(rise_cnt), 64'(n));
    endtask

    function automatic vec_t make_vec(input logic [1:0] len, input logic [31:0] tx,
                                      input logic [31:0] miso, input logic loop);
        vec_t v;
        logic [31:0] mask;
        v.len  = len;
        v.tx   = tx;
        v.miso = miso;
        v.loop = loop;
        v.n    = 8 * (int'(len) + 1);
        mask   = (v.n == 32) ? 32'hFFFF_FFFF : ((32'd1 << v.n) - 32'd1);
        v.exp_mosi = tx & mask;
        v.exp_rx   = loop ? (tx & mask) : (miso & mask);
        v.exp_lat  = CS_SETUP + 2 * v.n * CLK_DIV + CS_HOLD + 1;
        return v;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int waited;
        int d0;
        int b0;
        checks       = 0;
        failures     = 0;
        exp_dones    = 0;
        rst          = 1'b1;
        start        = 1'b0;
        SPI_DATA_LEN = 2'b00;
        tx_data      = '0;
        miso_pat     = '0;
        loopback     = 1'b0;

        vecs[0] = '{2'b00, 32'h0000_00A5, 32'h0000_003C, 1'b0, 8,  32'h0000_003C, 32'h0000_00A5, 35};
        vecs[1] = '{2'b11, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 32, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 131};
        vecs[2] = '{2'b01, 32'hFFFF_1234, 32'hFFFF_FFFF, 1'b0, 16, 32'h0000_FFFF, 32'h0000_1234, 67};
        vecs[3] = '{2'b10, 32'h12AB_CDEF, 32'hFF5A_5A5A, 1'b0, 24, 32'h005A_5A5A, 32'h00AB_CDEF, 99};
        for (int i = 4; i < NVEC; i++) begin
            vecs[i] = make_vec(2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({CS_n, SCLK, MOSI, busy, done, rx_data}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}));
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            push_exp(vecs[i]);
            pulse_start(vecs[i].len, vecs[i].tx);
            exp_dones++;
            wait_done(0, 300);
            repeat (2) @(negedge clk);
        end

        // Second start at the 3rd rising edge must be ignored.
        d0 = done_cnt;
        b0 = busy_falls;
        push_exp(vecs[0]);
        pulse_start(2'b00, 32'h0000_00A5);
        exp_dones++;
        wait_rises(3, 100, waited);
        start        = 1'b1;
        SPI_DATA_LEN = 2'b00;
        tx_data      = 32'h0000_0055;
        @(negedge clk);
        start = 1'b0;
        wait_done(waited + 1, 300);
        repeat (60) @(negedge clk);
        check("busy_start_single_done", 64'(done_cnt), 64'(d0 + 1));
        check("busy_start_single_fall", 64'(busy_falls), 64'(b0 + 1));
        check("busy_start_idle", 64'(busy), 64'd0);

        // One-cycle reset at the 5th rising edge aborts the transfer.
        pulse_start(2'b00, 32'h0000_00A5);
        miso_pat = 32'h0000_00FF;
        wait_rises(5, 100, waited);
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", 64'({CS_n, SCLK, MOSI, busy, done, rx_data}),
              64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}));
        rst = 1'b0;
        d0  = done_cnt;
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(done_cnt), 64'(d0));
        push_exp(make_vec(2'b00, 32'h0000_0096, 32'h0000_00C3, 1'b0));
        pulse_start(2'b00, 32'h0000_0096);
        exp_dones++;
        wait_done(0, 300);
        repeat (2) @(negedge clk);

        // Back-to-back: start in the first IDLE cycle after done.
        push_exp(make_vec(2'b01, 32'h0000_C3A5, 32'h0000_7E81, 1'b0));
        pulse_start(2'b01, 32'h0000_C3A5);
        exp_dones++;
        wait_done(0, 300);
        check("b2b_cs_idle_high", 64'(CS_n), 64'd1);
        push_exp(make_vec(2'b00, 32'h0000_005A, 32'h0000_0099, 1'b0));
        pulse_start(2'b00, 32'h0000_005A);
        exp_dones++;
        check("b2b_cs_low_again", 64'(CS_n), 64'd0);
        wait_done(0, 300);
        repeat (4) @(negedge clk);

        check("done_count", 64'(done_cnt), 64'(exp_dones));
        check("scoreboard_drained", 64'(exp_rx_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
